// File: rtl/lsu_pkg.sv
// lsu_pkg: shared load/store size encodings, FSM state type and alignment helpers
package lsu_pkg;
  localparam logic [2:0] LD_BYTE = 3'b000, LD_HALF = 3'b001, LD_WORD = 3'b010,
                         LD_BYTE_UN = 3'b100, LD_HALF_UN = 3'b101;
  localparam logic [2:0] ST_BYTE = 3'b000, ST_HALF = 3'b001, ST_WORD = 3'b010;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} lsu_state_t;
  function automatic logic size_ok(input logic we, input logic [2:0] size);
    return we ? (size == ST_BYTE || size == ST_HALF || size == ST_WORD)
              : (size == LD_BYTE || size == LD_HALF || size == LD_WORD ||
                 size == LD_BYTE_UN || size == LD_HALF_UN);
  endfunction
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    return (size[1:0] == 2'b01 && off[0]) || (size[1:0] == 2'b10 && off != 2'b00);
  endfunction
  function automatic logic [1:0] align_off(input logic [2:0] size, input logic [1:0] off);
    return size[1:0] == 2'b01 ? {off[1], 1'b0} : size[1:0] == 2'b10 ? 2'b00 : off;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the raw word by byte offset and sign/zero-extends per load size
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] data
);
  logic [31:0] word;
  assign word = rdata >> {offset, 3'b000};
  assign data = size == LD_BYTE    ? {{24{word[7]}}, word[7:0]} :
                size == LD_HALF    ? {{16{word[15]}}, word[15:0]} :
                size == LD_BYTE_UN ? {24'b0, word[7:0]} :
                size == LD_HALF_UN ? {16'b0, word[15:0]} : word;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer (core req/rsp <-> word memory port); define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  lsu_state_t state_q, state_d;
  logic we_q, we_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, accept, bad;
  logic [2:0] size_q, size_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d, ld_data;
  logic [CW-1:0] cnt_q, cnt_d;
  lsu_load_align u_align (.rdata(mem_rdata), .offset(addr_q[1:0]), .size(size_q), .data(ld_data));
  assign req_ready = state_q == IDLE;
  assign accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = !size_ok(req_we, req_size) || misaligned(req_size, req_addr[1:0]);
`else
  assign bad = !size_ok(req_we, req_size);
`endif
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: if (accept) begin
        if (bad) begin
          rsp_valid_d = 1'b1;
          rsp_err_d = 1'b1;
        end else begin
          state_d = ISSUE;
          we_d = req_we;
          size_d = req_size;
          addr_d = {req_addr[AWIDTH-1:2], align_off(req_size, req_addr[1:0])};
          wdata_d = req_wdata;
        end
      end
      ISSUE: if (mem_req_ready) begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rsp_valid) begin
          state_d = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : ld_data;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy = state_q != IDLE;
  assign mem_req_valid = state_q == ISSUE;
  assign mem_addr = mem_req_valid ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
  assign mem_we = mem_req_valid && we_q;
  assign mem_wmask = !mem_we ? 4'b0000 :
                     size_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                     size_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'hF;
  assign mem_wdata = !mem_we ? '0 :
                     size_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                     size_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;
  import lsu_pkg::*;
  localparam int TIMEOUT = 255;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, mem_req_ready = 0, mem_rsp_valid = 0;
  logic [2:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic req_ready, rsp_valid, rsp_err, mem_req_valid, mem_we, busy;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;
  rsp_t exp_q[$];
  int checks = 0, errors = 0;
  lsu_ctrl #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst && rsp_valid) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rsp: got err=%0b rdata=0x%08h expected no response", rsp_err, rsp_rdata);
    end else begin
      rsp_t e;
      e = exp_q.pop_front();
      check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      check("rsp_rdata", rsp_rdata, e.rdata);
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic we, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 0; req_we = 0; req_size = 0; req_addr = 0; req_wdata = 0;
  endtask
  task automatic load(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] raw,
                      input logic [31:0] exp, input int delay);
    send(0, size, addr, 0);
    repeat (delay) begin
      check("mem_req_valid_hold", {31'b0, mem_req_valid}, 32'd1);
      check("mem_addr_hold", mem_addr, addr & 32'hFFFF_FFFC);
      step();
    end
    check("mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
    check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
    check("mem_we_load", {31'b0, mem_we}, 32'd0);
    check("mem_wmask_load", {28'b0, mem_wmask}, 32'd0);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = raw;
    exp_q.push_back('{err: 1'b0, rdata: exp});
    step();
    mem_rsp_valid = 0; mem_rdata = 0;
    check("rsp_valid_latency", {31'b0, rsp_valid}, 32'd1);
    check("req_ready_in_rsp", {31'b0, req_ready}, 32'd1);
  endtask
  task automatic store(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] rep);
    send(1, size, addr, wdata);
    check("mem_we_store", {31'b0, mem_we}, 32'd1);
    check("mem_wmask", {28'b0, mem_wmask}, {28'b0, mask});
    check("mem_wdata", mem_wdata, rep);
    check("mem_addr_store", mem_addr, addr & 32'hFFFF_FFFC);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1;
    exp_q.push_back('{err: 1'b0, rdata: 32'h0});
    step();
    check("rsp_valid_store", {31'b0, rsp_valid}, 32'd1);
    step();
    mem_rsp_valid = 0;
    check("second_ack_ignored", {31'b0, rsp_valid}, 32'd0);
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_mem_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_wmask"}, {28'b0, mem_wmask}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    step(3);
    check_idle_outputs("reset");
    rst = 0;
    step();
    load(LD_BYTE, 32'h1003, 32'h80FF1234, 32'hFFFFFF80, 0);
    load(LD_HALF_UN, 32'h1002, 32'hBEEF0000, 32'h0000BEEF, 4);
    load(LD_HALF, 32'h1000, 32'h00008001, 32'hFFFF8001, 1);
    load(LD_BYTE_UN, 32'h1001, 32'h0000A500, 32'h000000A5, 0);
    load(LD_BYTE, 32'h1002, 32'h007F0000, 32'h0000007F, 0);
    load(LD_WORD, 32'h1004, 32'h12345678, 32'h12345678, 2);
    store(ST_BYTE, 32'h2001, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    store(ST_BYTE, 32'h2003, 32'h0000003C, 4'b1000, 32'h3C3C3C3C);
    store(ST_HALF, 32'h2002, 32'h00001234, 4'b1100, 32'h12341234);
    store(ST_WORD, 32'h2000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    send(0, LD_WORD, 32'h4000, 0);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    n = 0;
    while (n < TIMEOUT + 10 && !rsp_valid) begin
      step();
      n++;
    end
    check("timeout_cycles", n, TIMEOUT + 1);
    load(LD_WORD, 32'h4004, 32'h0BADF00D, 32'h0BADF00D, 0);
    send(0, 3'b011, 32'h5000, 0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    check("illegal_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("illegal_no_mem", {31'b0, mem_req_valid}, 32'd0);
    step();
    check("illegal_no_mem_later", {31'b0, mem_req_valid}, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    send(0, LD_WORD, 32'h3002, 0);
    exp_q.push_back('{err: 1'b1, rdata: 32'h0});
    check("misalign_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("misalign_no_mem", {31'b0, mem_req_valid}, 32'd0);
    step();
    check("misalign_no_mem_later", {31'b0, mem_req_valid}, 32'd0);
`else
    load(LD_WORD, 32'h3002, 32'hCAFEF00D, 32'hCAFEF00D, 0);
`endif
    send(0, LD_WORD, 32'h6000, 0);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    check("wait_busy", {31'b0, busy}, 32'd1);
    rst = 1;
    step();
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 0; mem_rsp_valid = 1; mem_rdata = 32'h55555555;
    step();
    mem_rsp_valid = 0;
    check_idle_outputs("post_rst");
    step(2);
    check("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
